// File: rtl/aesl_deadlock_monitor_unit_pkg.sv
// Shared types and helpers for the per-process deadlock monitor.
package aesl_dl_pkg;

  // Report FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_REPORTED = 2'd2
  } dl_state_e;

  // Token arbitration modes
  localparam int unsigned TOKEN_FIXED = 0;
  localparam int unsigned TOKEN_RR    = 1;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // One-hot of an index; callers cast down to their vector width (<= 32)
  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'(1) << idx;
  endfunction

endpackage

// File: rtl/aesl_deadlock_monitor_unit_if.sv
// Dependency/token channel bundle between a process wrapper and its monitor.
interface aesl_deadlock_monitor_unit_if #(
  parameter int unsigned PROC_NUM     = 4,
  parameter int unsigned IN_CHAN_NUM  = 2,
  parameter int unsigned OUT_CHAN_NUM = 3,
  parameter int unsigned TS_WIDTH     = 32
);
  logic [OUT_CHAN_NUM-1:0]          proc_dep_vld_vec;
  logic [IN_CHAN_NUM-1:0]           in_chan_dep_vld_vec;
  logic [IN_CHAN_NUM*PROC_NUM-1:0]  in_chan_dep_data_vec;
  logic [IN_CHAN_NUM-1:0]           token_in_vec;
  logic                             dl_detect_in;
  logic                             origin;
  logic                             token_clear;
  logic                             dl_ack;
  logic [OUT_CHAN_NUM-1:0]          out_chan_dep_vld_vec;
  logic [PROC_NUM-1:0]              out_chan_dep_data;
  logic [OUT_CHAN_NUM-1:0]          token_out_vec;
  logic                             dl_detect_out;
  logic                             dl_confirmed;
  logic [TS_WIDTH-1:0]              dl_timestamp;

  modport master (
    output proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec,
           token_in_vec, dl_detect_in, origin, token_clear, dl_ack,
    input  out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec,
           dl_detect_out, dl_confirmed, dl_timestamp
  );

  modport slave (
    input  proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec,
           token_in_vec, dl_detect_in, origin, token_clear, dl_ack,
    output out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec,
           dl_detect_out, dl_confirmed, dl_timestamp
  );
endinterface

// File: rtl/aesl_deadlock_monitor_unit_token_arbiter.sv
// Picks which blocked outgoing channel receives the report token.
module aesl_dl_token_arbiter
  import aesl_dl_pkg::*;
#(
  parameter int unsigned OUT_CHAN_NUM = 3,
  parameter int unsigned TOKEN_RR     = 0,
  localparam int unsigned PTR_W       = (OUT_CHAN_NUM > 1) ? clog2(OUT_CHAN_NUM) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OUT_CHAN_NUM-1:0] req,
  input  logic                    advance,
  input  logic                    clear,
  output logic [OUT_CHAN_NUM-1:0] grant,
  output logic [PTR_W-1:0]        ptr
);

  localparam bit RR_MODE = (TOKEN_RR == aesl_dl_pkg::TOKEN_RR);

  logic [PTR_W-1:0] cand_idx;
  int unsigned      probe;

  // Candidate channel: highest request, or first request after ptr in RR mode
  always_comb begin
    cand_idx = '0;
    probe    = 0;
    if (RR_MODE) begin
      // Descending scan so the nearest channel after ptr is written last
      for (int unsigned k = OUT_CHAN_NUM; k > 0; k--) begin
        probe = (32'(ptr) + k) % OUT_CHAN_NUM;
        if (req[probe]) cand_idx = PTR_W'(probe);
      end
    end else begin
      for (int unsigned j = 0; j < OUT_CHAN_NUM; j++) begin
        if (req[j]) cand_idx = PTR_W'(j);
      end
    end
  end

  // Token is passed on for one cycle per accepted advance
  always_ff @(posedge clock) begin
    if (reset) begin
      grant <= '0;
      ptr   <= PTR_W'(OUT_CHAN_NUM - 1);
    end else if (advance && !clear) begin
      grant <= OUT_CHAN_NUM'(onehot(32'(cand_idx)));
      ptr   <= cand_idx;
    end else begin
      grant <= '0;
    end
  end

endmodule

// File: rtl/aesl_deadlock_monitor_unit.sv
// Per-process deadlock monitor: dependency merge, confirmation, sticky report, token pass.
module aesl_deadlock_monitor_unit
  import aesl_dl_pkg::*;
#(
  parameter int unsigned PROC_NUM       = 4,
  parameter int unsigned PROC_ID        = 0,
  parameter int unsigned IN_CHAN_NUM    = 2,
  parameter int unsigned OUT_CHAN_NUM   = 3,
  parameter int unsigned CONFIRM_CYCLES = 16,
  parameter int unsigned TOKEN_RR       = TOKEN_FIXED,
  parameter int unsigned TS_WIDTH       = 32
) (
  input logic                   clock,
  input logic                   reset,
  aesl_deadlock_monitor_unit_if.slave bus
);

  localparam int unsigned     CNT_W    = clog2(CONFIRM_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam int unsigned     PTR_W    = (OUT_CHAN_NUM > 1) ? clog2(OUT_CHAN_NUM) : 1;

  logic [PROC_NUM-1:0] merged_c;
  logic [PROC_NUM-1:0] dep_c;
  logic [PROC_NUM-1:0] dep_reg;
  logic                pass_c;
  logic                blocked_c;
  logic                raw_hit_c;
  logic                detect_c;
  logic                ack_c;
  logic [CNT_W-1:0]    cnt;
  logic [TS_WIDTH-1:0] ts;
  dl_state_e           state;
  logic                confirmed;
  logic [TS_WIDTH-1:0] timestamp;
  logic [PTR_W-1:0]    unused_tok_ptr;

  // OR together the dependency vectors of all valid incoming channels
  always_comb begin
    merged_c = '0;
    for (int unsigned i = 0; i < IN_CHAN_NUM; i++) begin
      if (bus.in_chan_dep_vld_vec[i]) merged_c = merged_c | bus.in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
    end
  end

  // While a deadlock is being reported without a token, keep the old vector
  assign pass_c    = ~bus.dl_detect_in | (|bus.token_in_vec);
  assign dep_c     = pass_c ? merged_c : dep_reg;
  assign blocked_c = |bus.proc_dep_vld_vec;
  assign raw_hit_c = pass_c & dep_c[PROC_ID] & blocked_c;
  assign detect_c  = raw_hit_c & (cnt == CNT_LAST);
  assign ack_c     = bus.dl_ack & (state == ST_REPORTED);

  // Dependency register, dropped when the process is no longer blocked
  always_ff @(posedge clock) begin
    if (reset) dep_reg <= '0;
    else       dep_reg <= blocked_c ? dep_c : '0;
  end

  // Consecutive self-dependency counter, saturating; any gap or ack restarts it
  always_ff @(posedge clock) begin
    if (reset)                   cnt <= '0;
    else if (!raw_hit_c || ack_c) cnt <= '0;
    else if (cnt != CNT_LAST)    cnt <= cnt + CNT_W'(1);
  end

  // Free-running timestamp, wraps naturally
  always_ff @(posedge clock) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_WIDTH'(1);
  end

  // Report FSM with sticky flag and timestamp capture on entry to REPORTED
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      confirmed <= 1'b0;
      timestamp <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ARMED: begin
          if (detect_c) begin
            state     <= ST_REPORTED;
            confirmed <= 1'b1;
            timestamp <= ts;
          end else if (raw_hit_c) begin
            state <= ST_ARMED;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REPORTED: begin
          if (bus.dl_ack) begin
            state     <= ST_IDLE;
            confirmed <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          confirmed <= 1'b0;
        end
      endcase
    end
  end

  // Token arbiter; origin forces an advance and overrides token_clear
  aesl_dl_token_arbiter #(
    .OUT_CHAN_NUM (OUT_CHAN_NUM),
    .TOKEN_RR     (TOKEN_RR)
  ) u_token_arbiter (
    .clock   (clock),
    .reset   (reset),
    .req     (bus.proc_dep_vld_vec),
    .advance ((|bus.token_in_vec) | bus.origin),
    .clear   (bus.token_clear & ~bus.origin),
    .grant   (bus.token_out_vec),
    .ptr     (unused_tok_ptr)
  );

  assign bus.out_chan_dep_vld_vec = bus.proc_dep_vld_vec;
  assign bus.out_chan_dep_data    = dep_reg | PROC_NUM'(onehot(PROC_ID));
  assign bus.dl_detect_out        = detect_c;
  assign bus.dl_confirmed         = confirmed;
  assign bus.dl_timestamp         = timestamp;

endmodule

// File: tb/tb_aesl_deadlock_monitor_unit.sv
// Directed bench: A = fixed-priority tokens, B = round-robin tokens, C = 4-bit timestamp.
module tb_aesl_deadlock_monitor_unit;
  import aesl_dl_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [31:0] ts_exp;

  always #5 clock = ~clock;

  aesl_deadlock_monitor_unit_if #(.PROC_NUM(4), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3), .TS_WIDTH(32)) ifa ();
  aesl_deadlock_monitor_unit_if #(.PROC_NUM(4), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3), .TS_WIDTH(32)) ifb ();
  aesl_deadlock_monitor_unit_if #(.PROC_NUM(4), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3), .TS_WIDTH(4))  ifc ();

  aesl_deadlock_monitor_unit #(.PROC_NUM(4), .PROC_ID(0), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3),
    .CONFIRM_CYCLES(4), .TOKEN_RR(TOKEN_FIXED), .TS_WIDTH(32)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
  aesl_deadlock_monitor_unit #(.PROC_NUM(4), .PROC_ID(0), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3),
    .CONFIRM_CYCLES(4), .TOKEN_RR(TOKEN_RR), .TS_WIDTH(32)) dut_b (.clock(clock), .reset(reset), .bus(ifb));
  aesl_deadlock_monitor_unit #(.PROC_NUM(4), .PROC_ID(0), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3),
    .CONFIRM_CYCLES(4), .TOKEN_RR(TOKEN_FIXED), .TS_WIDTH(4)) dut_c (.clock(clock), .reset(reset), .bus(ifc));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; ts inside the DUTs equals cyc during the following cycle
  task automatic tick();
    logic rst_seen;
    @(posedge clock);
    rst_seen = reset;
    #1;
    cyc = rst_seen ? 0 : cyc + 1;
  endtask

  initial begin
    ifa.proc_dep_vld_vec = '0; ifa.in_chan_dep_vld_vec = '0; ifa.in_chan_dep_data_vec = '0;
    ifa.token_in_vec = '0; ifa.dl_detect_in = 1'b0; ifa.origin = 1'b0; ifa.token_clear = 1'b0; ifa.dl_ack = 1'b0;
    ifb.proc_dep_vld_vec = '0; ifb.in_chan_dep_vld_vec = '0; ifb.in_chan_dep_data_vec = '0;
    ifb.token_in_vec = '0; ifb.dl_detect_in = 1'b0; ifb.origin = 1'b0; ifb.token_clear = 1'b0; ifb.dl_ack = 1'b0;
    ifc.proc_dep_vld_vec = '0; ifc.in_chan_dep_vld_vec = '0; ifc.in_chan_dep_data_vec = '0;
    ifc.token_in_vec = '0; ifc.dl_detect_in = 1'b0; ifc.origin = 1'b0; ifc.token_clear = 1'b0; ifc.dl_ack = 1'b0;

    // Reset values
    tick(); tick();
    reset = 1'b0;
    chk("rst_a_token", 64'(ifa.token_out_vec), 64'(0));
    chk("rst_a_conf",  64'(ifa.dl_confirmed), 64'(0));
    chk("rst_a_ts",    64'(ifa.dl_timestamp), 64'(0));
    chk("rst_a_data",  64'(ifa.out_chan_dep_data), 64'(4'b0001));
    chk("rst_a_det",   64'(ifa.dl_detect_out), 64'(0));
    chk("rst_b_token", 64'(ifb.token_out_vec), 64'(0));
    chk("rst_c_ts",    64'(ifc.dl_timestamp), 64'(0));

    // Merge two channels, then hold the vector while a report is in flight
    ifa.in_chan_dep_vld_vec = 2'b11;
    ifa.in_chan_dep_data_vec = {4'b0100, 4'b0010};
    ifa.proc_dep_vld_vec = 3'b001;
    #1;
    chk("merge_vld_pass", 64'(ifa.out_chan_dep_vld_vec), 64'(3'b001));
    chk("merge_det",      64'(ifa.dl_detect_out), 64'(0));
    chk("merge_lag",      64'(ifa.out_chan_dep_data), 64'(4'b0001));
    tick();
    chk("merge_data",     64'(ifa.out_chan_dep_data), 64'(4'b0111));
    ifa.dl_detect_in = 1'b1;
    ifa.in_chan_dep_data_vec = {4'b0000, 4'b1000};
    tick();
    chk("hold_data",      64'(ifa.out_chan_dep_data), 64'(4'b0111));
    ifa.proc_dep_vld_vec = 3'b000;
    tick();
    chk("unblock_data",   64'(ifa.out_chan_dep_data), 64'(4'b0001));
    ifa.dl_detect_in = 1'b0;
    ifa.in_chan_dep_vld_vec = 2'b00;
    tick();

    // Four consecutive self-dependency cycles confirm a deadlock
    ifa.in_chan_dep_vld_vec = 2'b01;
    ifa.in_chan_dep_data_vec = {4'b0000, 4'b0001};
    ifa.proc_dep_vld_vec = 3'b001;
    #1;
    chk("conf_h1_det", 64'(ifa.dl_detect_out), 64'(0));
    tick();
    chk("conf_h2_det", 64'(ifa.dl_detect_out), 64'(0));
    tick();
    chk("conf_h3_det", 64'(ifa.dl_detect_out), 64'(0));
    tick();
    chk("conf_h4_det", 64'(ifa.dl_detect_out), 64'(1));
    chk("conf_h4_conf", 64'(ifa.dl_confirmed), 64'(0));
    ts_exp = 32'(cyc);
    tick();
    chk("conf_flag", 64'(ifa.dl_confirmed), 64'(1));
    chk("conf_ts",   64'(ifa.dl_timestamp), 64'(ts_exp));

    // Ack while still hitting: back to idle, needs four fresh hits
    ifa.dl_ack = 1'b1;
    tick();
    ifa.dl_ack = 1'b0;
    chk("ack_conf_low", 64'(ifa.dl_confirmed), 64'(0));
    chk("ack_r1_det",   64'(ifa.dl_detect_out), 64'(0));
    tick();
    chk("ack_r2_det",   64'(ifa.dl_detect_out), 64'(0));
    tick();
    chk("ack_r3_det",   64'(ifa.dl_detect_out), 64'(0));
    tick();
    chk("ack_r4_det",   64'(ifa.dl_detect_out), 64'(1));
    ts_exp = 32'(cyc);
    tick();
    chk("rerep_conf",   64'(ifa.dl_confirmed), 64'(1));
    chk("rerep_ts",     64'(ifa.dl_timestamp), 64'(ts_exp));
    ifa.dl_ack = 1'b1;
    ifa.proc_dep_vld_vec = 3'b000;
    ifa.in_chan_dep_vld_vec = 2'b00;
    tick();
    ifa.dl_ack = 1'b0;
    chk("clr_conf", 64'(ifa.dl_confirmed), 64'(0));
    chk("clr_ts_hold", 64'(ifa.dl_timestamp), 64'(ts_exp));

    // A gap at the third hit restarts the count
    ifa.in_chan_dep_vld_vec = 2'b01;
    ifa.proc_dep_vld_vec = 3'b001;
    #1;
    chk("brk_c1_det", 64'(ifa.dl_detect_out), 64'(0));
    tick();
    chk("brk_c2_det", 64'(ifa.dl_detect_out), 64'(0));
    tick();
    ifa.in_chan_dep_vld_vec = 2'b00;
    #1;
    chk("brk_c3_det", 64'(ifa.dl_detect_out), 64'(0));
    tick();
    ifa.in_chan_dep_vld_vec = 2'b01;
    #1;
    chk("brk_c4_det", 64'(ifa.dl_detect_out), 64'(0));
    tick();
    chk("brk_c5_det", 64'(ifa.dl_detect_out), 64'(0));
    chk("brk_c5_conf", 64'(ifa.dl_confirmed), 64'(0));
    tick();
    chk("brk_c6_det", 64'(ifa.dl_detect_out), 64'(0));
    tick();
    chk("brk_c7_det", 64'(ifa.dl_detect_out), 64'(1));
    tick();
    chk("brk_conf", 64'(ifa.dl_confirmed), 64'(1));
    ifa.in_chan_dep_vld_vec = 2'b00;
    ifa.proc_dep_vld_vec = 3'b000;
    ifa.dl_ack = 1'b1;
    tick();
    ifa.dl_ack = 1'b0;
    chk("brk_ack", 64'(ifa.dl_confirmed), 64'(0));

    // Fixed-priority tokens
    ifa.proc_dep_vld_vec = 3'b011;
    ifa.origin = 1'b1;
    tick();
    ifa.origin = 1'b0;
    chk("fp_origin", 64'(ifa.token_out_vec), 64'(3'b010));
    ifa.token_in_vec = 2'b01;
    ifa.token_clear = 1'b1;
    tick();
    chk("fp_clear", 64'(ifa.token_out_vec), 64'(3'b000));
    ifa.token_clear = 1'b0;
    tick();
    chk("fp_tokin", 64'(ifa.token_out_vec), 64'(3'b010));
    ifa.token_in_vec = 2'b00;
    ifa.origin = 1'b1;
    ifa.token_clear = 1'b1;
    tick();
    chk("fp_origin_over_clear", 64'(ifa.token_out_vec), 64'(3'b010));
    ifa.token_clear = 1'b0;
    ifa.proc_dep_vld_vec = 3'b000;
    tick();
    chk("fp_no_req", 64'(ifa.token_out_vec), 64'(3'b001));
    ifa.origin = 1'b0;
    tick();
    chk("fp_idle", 64'(ifa.token_out_vec), 64'(3'b000));

    // Round-robin tokens
    ifb.proc_dep_vld_vec = 3'b111;
    ifb.origin = 1'b1;
    tick();
    chk("rr_1", 64'(ifb.token_out_vec), 64'(3'b001));
    tick();
    chk("rr_2", 64'(ifb.token_out_vec), 64'(3'b010));
    tick();
    chk("rr_3", 64'(ifb.token_out_vec), 64'(3'b100));
    tick();
    chk("rr_4", 64'(ifb.token_out_vec), 64'(3'b001));
    ifb.proc_dep_vld_vec = 3'b101;
    tick();
    chk("rr_skip", 64'(ifb.token_out_vec), 64'(3'b100));
    tick();
    chk("rr_wrap", 64'(ifb.token_out_vec), 64'(3'b001));
    ifb.origin = 1'b0;
    tick();
    chk("rr_idle", 64'(ifb.token_out_vec), 64'(3'b000));

    // 4-bit timestamp: detection at ts=15, next one after wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("c_rst_conf", 64'(ifc.dl_confirmed), 64'(0));
    for (int i = 0; i < 40 && cyc < 12; i++) tick();
    ifc.in_chan_dep_vld_vec = 2'b01;
    ifc.in_chan_dep_data_vec = {4'b0000, 4'b0001};
    ifc.proc_dep_vld_vec = 3'b001;
    tick(); tick();
    chk("c_h3_det", 64'(ifc.dl_detect_out), 64'(0));
    tick();
    chk("c_h4_det", 64'(ifc.dl_detect_out), 64'(1));
    tick();
    chk("c_conf", 64'(ifc.dl_confirmed), 64'(1));
    chk("c_ts_f", 64'(ifc.dl_timestamp), 64'(4'hF));
    ifc.dl_ack = 1'b1;
    tick();
    ifc.dl_ack = 1'b0;
    chk("c_ack", 64'(ifc.dl_confirmed), 64'(0));
    tick(); tick(); tick();
    chk("c_r4_det", 64'(ifc.dl_detect_out), 64'(1));
    tick();
    chk("c_conf2", 64'(ifc.dl_confirmed), 64'(1));
    chk("c_ts_wrap", 64'(ifc.dl_timestamp), 64'(4'h4));

    // Reset during a report clears flag and timestamp on the same edge
    reset = 1'b1;
    tick();
    chk("c_rst_mid_conf", 64'(ifc.dl_confirmed), 64'(0));
    chk("c_rst_mid_ts",   64'(ifc.dl_timestamp), 64'(0));
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
